// File: rtl/shift_pattern_sequencer_if.sv
// Bundle of the run-request and result signals between the switch/key side
// and the pattern sequencer. The controller side drives the request, and the
// sequencer reports the serial stream and the run results.
interface shift_pattern_sequencer_if #(
  parameter int WIDTH   = 10,
  parameter int COUNT_W = 4
);
  logic               start;
  logic               pause;
  logic [WIDTH-1:0]   pattern;
  logic               serial_out;
  logic [WIDTH-1:0]   shift_data;
  logic [COUNT_W-1:0] bit_index;
  logic [COUNT_W-1:0] match_count;
  logic               busy;
  logic               done;

  modport master (
    output start, pause, pattern,
    input  serial_out, shift_data, bit_index, match_count, busy, done
  );

  modport slave (
    input  start, pause, pattern,
    output serial_out, shift_data, bit_index, match_count, busy, done
  );
endinterface

// File: rtl/shift_pattern_sequencer.sv
// Pattern run sequencer: captures a parallel pattern on start, shifts it out
// LSB-first one bit per unpaused clock, counts 0->1 transitions in the serial
// stream and pulses done for one cycle at the end of the run.
module shift_pattern_sequencer #(
  parameter int WIDTH   = 10,
  parameter int COUNT_W = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  shift_pattern_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [COUNT_W-1:0] LAST_IDX  = COUNT_W'(WIDTH - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  state_t state;
  logic   prev_bit;

  // The serial bit is only meaningful while shifting; it is forced low otherwise.
  assign bus.serial_out = (state == SHIFT) ? bus.shift_data[0] : 1'b0;

  // Run control, shift register, transition counter and registered status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      bus.shift_data  <= '0;
      bus.bit_index   <= '0;
      bus.match_count <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      prev_bit        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            bus.shift_data  <= bus.pattern;
            bus.bit_index   <= '0;
            bus.match_count <= '0;
            prev_bit        <= 1'b1;
            bus.busy        <= 1'b1;
            state           <= SHIFT;
          end
        end
        SHIFT: begin
          if (!bus.pause) begin
            bus.shift_data <= {1'b0, bus.shift_data[WIDTH-1:1]};
            if (!prev_bit && bus.shift_data[0] && (bus.match_count != COUNT_MAX)) begin
              bus.match_count <= bus.match_count + 1'b1;
            end
            prev_bit      <= bus.shift_data[0];
            bus.bit_index <= bus.bit_index + 1'b1;
            if (bus.bit_index == LAST_IDX) begin
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
